uart_debug_master: RTL and testbench
====================================

# uart_debug_master

Serial debug/loader initiator that drives the peripheral register bus from a host PC. It receives command frames on a UART line, issues single 32-bit writes or reads on the same `wr_*`/`rd_*` bus the memory-mapped peripherals respond to, and returns an acknowledgement or the read data over its own UART transmitter. It sits beside the CPU bus arbiter and asserts `halt_o` so the core stays off the bus for the duration of a frame.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `UART_BPS`, 115200: serial bit rate; `BAUD_CNT_MAX = CLK_FREQ / UART_BPS` clocks per bit, 16-bit counters.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout in clocks, used only with `UART_DBG_TIMEOUT_EN`.
- `sys_clk` in 1: system clock, all logic on the rising edge.
- `sys_reset` in 1: synchronous, active-high reset.
- `uart_rx` in 1: serial input from the host, asynchronous, idle high.
- `uart_tx` out 1: serial output to the host, idle high.
- `wr_en_o` out 1: bus write strobe, one cycle per write.
- `wr_addr_o` out 32: bus write address.
- `wr_data_o` out 32: bus write data.
- `rd_addr_o` out 32: bus read address; the target registers it internally.
- `rd_data_i` in 32: bus read data, valid 2 clocks after `rd_addr_o` changes.
- `halt_o` out 1: high while a frame is in progress; the core must not use the bus.

## Operation
- Reset values:
  - `uart_tx=1`, `wr_en_o=0`, `halt_o=0`.
  - `wr_addr_o`, `wr_data_o` and `rd_addr_o` are all 0.
  - All FSMs are in IDLE and all counters are 0.
- RX byte engine:
  - `uart_rx` passes through a 2-flop synchronizer.
  - In RX_IDLE, a synchronized 1→0 edge starts a frame.
  - The start bit is rechecked at `BAUD_CNT_MAX/2-1`; if it reads 1, return to RX_IDLE.
  - 8 data bits are sampled LSB first at mid-bit, then the stop bit at mid-bit.
  - Stop=1: a one-cycle `rx_valid` pulse with `rx_byte`.
  - Stop=0: framing error, byte dropped, the parser returns to P_IDLE without a response.
- TX byte engine:
  - Accepts a byte only when idle.
  - Sends start(0), 8 data bits LSB first, then stop(1), each `BAUD_CNT_MAX` clocks.
  - Pulses `tx_done` at the end of the stop bit.
- Parser FSM states: P_IDLE, P_ADDR, P_DATA, P_WRITE, P_READ, P_RESP.
  - P_IDLE, byte `0x57` ('W') or `0x52` ('R'): latch the command, set `halt_o=1`, go to P_ADDR.
  - P_IDLE, any other byte: queue NAK `0x15`, go to P_RESP.
  - P_ADDR: collect 4 bytes LSB first into the address.
    - After the 4th byte: 'W' goes to P_DATA; 'R' goes to P_READ.
  - P_DATA: collect 4 bytes LSB first, then go to P_WRITE.
  - P_WRITE: `wr_en_o=1` for exactly one cycle with address/data stable; queue ACK `0x06`; go to P_RESP.
  - P_READ: drive `rd_addr_o`, wait 2 clocks, capture `rd_data_i`, queue its 4 bytes LSB first, go to P_RESP.
  - P_RESP: send the queued bytes back to back. After the last `tx_done`, `halt_o=0` and go to P_IDLE.
- `wr_addr_o`, `wr_data_o` and `rd_addr_o` hold their last value between frames.
- Bytes received while in P_RESP are discarded.
- `sys_reset` mid-frame:
  - Aborts the frame and restores all reset values on the next edge.
  - `uart_tx` returns high immediately, truncating any character in progress.

## Timing
- Write strobe: `wr_en_o` is high on the clock after the `rx_valid` of the 9th frame byte.
- Read path:
  - `rd_addr_o` updates on the clock after the `rx_valid` of the 5th byte.
  - `rd_data_i` is captured 2 clocks after that.
  - The first response start bit begins on the next clock.
- ACK start bit begins 1 clock after the `wr_en_o` cycle.
- Response bytes are separated by zero idle bits.
- `halt_o` timing:
  - Rises on the clock after the command byte's `rx_valid`.
  - Falls on the clock after the final stop bit completes.

## Configuration
- `UART_DBG_TIMEOUT_EN` defined:
  - A counter clears on every `rx_valid` and runs in P_ADDR/P_DATA.
  - On reaching `TIMEOUT_CYCLES-1`, the frame is dropped: no bus access, no response, `halt_o=0`, P_IDLE.
- Not defined: no counter; the parser waits indefinitely for the remaining bytes.

## Test plan
Bench uses `CLK_FREQ=1_000_000` and `UART_BPS=100_000` (10 clocks/bit).
- Reset released, line idle → `uart_tx=1`, `halt_o=0`, `wr_en_o=0` held for 200 clocks.
- Send 57 10 00 00 20 EF BE AD DE → one `wr_en_o` pulse with `wr_addr_o=0x20000010` and `wr_data_o=0xDEADBEEF`; then serial `0x06` is returned.
- Send 52 08 00 00 20 with the bench model returning `0x12345678` → `rd_addr_o=0x20000008`; serial bytes 78 56 34 12 are returned.
- Send 0xA5 → serial `0x15` is returned, with no bus activity.
- Send 57 with stop bit forced 0 → no response and `halt_o` stays 0. Send 57 plus 2 address bytes, then idle for `TIMEOUT_CYCLES`:
  - With the macro: `halt_o` falls, no write occurs, and a following valid frame succeeds.
  - Without the macro: `halt_o` stays high.
- Assert `sys_reset` for 1 clock midway through the ACK transmission → `uart_tx=1` and `halt_o=0` on the next clock; a subsequent 'R' frame completes normally.

Source files
------------

// File: rtl/uart_debug_master.sv
`timescale 1ns/1ps
// uart_debug_master
// Host-driven bus initiator. Receives command frames over UART and issues
// single 32-bit writes or reads on the peripheral bus. It answers with an ACK
// byte, a NAK byte, or the four read-data bytes. halt_o keeps the CPU off the
// bus while a frame is in progress.
//   Frame 'W' (0x57): addr[4] data[4], LSB first -> one wr_en_o pulse, ACK 0x06
//   Frame 'R' (0x52): addr[4], LSB first         -> 4 read-data bytes, LSB first
//   Any other first byte                          -> NAK 0x15
// Ports:
//   sys_clk, sys_reset (sync, active high)
//   uart_rx  (async serial in), uart_tx (serial out, idle high)
//   wr_en_o / wr_addr_o / wr_data_o : write strobe, address, data
//   rd_addr_o / rd_data_i           : read address out, data in (2 clocks later)
//   halt_o                          : high while a W/R frame is in progress
// Optional feature macro: UART_DBG_TIMEOUT_EN (inter-byte timeout drops the frame).
module uart_debug_master #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int UART_BPS       = 115200,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [31:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        halt_o
);
  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] BAUD_MID     = 16'(BAUD_CNT_MAX / 2 - 1);
  localparam logic [7:0]  CMD_W = 8'h57, CMD_R = 8'h52, ACK = 8'h06, NAK = 8'h15;

  // ---------------- RX byte engine ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t   r_rx_state, w_rx_next;
  logic [2:0]  r_rx_sync;  // [0] first flop, [1] synchronized bit, [2] previous for edge detect
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid, r_rx_err;
  logic        w_rx_fall, w_rx_mid, w_rx_tick;

  assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];
  assign w_rx_mid  = (r_rx_cnt == BAUD_MID);
  assign w_rx_tick = (r_rx_cnt == BAUD_LAST);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_mid) w_rx_next = r_rx_sync[1] ? RX_IDLE : RX_DATA;  // glitch rejection
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_rx_sync  <= 3'b111;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[1:0], uart_rx};
      r_rx_state <= w_rx_next;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      // Counter restarts at mid-start so every later tick lands mid-bit.
      if (r_rx_state == RX_IDLE || (r_rx_state == RX_START && w_rx_mid) || w_rx_tick)
        r_rx_cnt <= '0;
      else
        r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_state == RX_START && w_rx_mid) r_rx_bit <= '0;
      if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_byte <= {r_rx_sync[1], r_rx_byte[7:1]};
        r_rx_bit  <= r_rx_bit + 3'd1;
      end
      if (r_rx_state == RX_STOP && w_rx_tick) begin
        r_rx_valid <= r_rx_sync[1];
        r_rx_err   <= ~r_rx_sync[1];
      end
    end
  end

  // ---------------- TX byte engine ----------------
  // r_tx_bit: 0 start, 1..8 data, 9 stop. A new byte may load in the cycle
  // the stop bit ends, so response bytes follow with no idle bits.
  logic        r_tx_busy, r_tx;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic [7:0]  r_tx_data;
  logic        w_tx_tick, w_tx_done, w_tx_start;
  logic [7:0]  w_tx_byte;

  assign w_tx_tick = (r_tx_cnt == BAUD_LAST);
  assign w_tx_done = r_tx_busy && w_tx_tick && (r_tx_bit == 4'd9);

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_tx_busy <= 1'b0;
      r_tx      <= 1'b1;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_data <= '0;
    end else if (w_tx_start && (!r_tx_busy || w_tx_done)) begin
      r_tx_busy <= 1'b1;
      r_tx      <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_data <= w_tx_byte;
    end else if (r_tx_busy) begin
      if (w_tx_tick) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
          r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_data[r_tx_bit[2:0]];
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
    end
  end

  // ---------------- Frame parser ----------------
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_WRITE, P_READ, P_RESP} p_state_t;
  p_state_t    r_p_state, w_p_next;
  logic        r_is_wr, r_rd_wait, r_wr_en, r_halt;
  logic [1:0]  r_bcnt;
  logic [2:0]  r_resp_left;
  logic [31:0] r_addr, r_data, r_resp, r_wr_addr, r_wr_data, r_rd_addr;
  logic        w_cmd_ok, w_last_byte, w_timeout, w_collect;

  assign w_cmd_ok    = (r_rx_byte == CMD_W) || (r_rx_byte == CMD_R);
  assign w_last_byte = r_rx_valid && (r_bcnt == 2'd3);
  assign w_collect   = (r_p_state == P_ADDR) || (r_p_state == P_DATA);

`ifdef UART_DBG_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  always_ff @(posedge sys_clk) begin
    if (sys_reset || r_rx_valid || !w_collect) r_to_cnt <= '0;
    else                                      r_to_cnt <= r_to_cnt + 32'd1;
  end
  assign w_timeout = w_collect && !r_rx_valid && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_p_next   = r_p_state;
    w_tx_start = 1'b0;
    w_tx_byte  = NAK;
    case (r_p_state)
      P_IDLE:
        if (r_rx_valid) begin
          if (w_cmd_ok) w_p_next = P_ADDR;
          else begin
            w_p_next   = P_RESP;
            w_tx_start = 1'b1;
            w_tx_byte  = NAK;
          end
        end
      P_ADDR:
        if (r_rx_err || w_timeout) w_p_next = P_IDLE;
        else if (w_last_byte)      w_p_next = r_is_wr ? P_DATA : P_READ;
      P_DATA:
        if (r_rx_err || w_timeout) w_p_next = P_IDLE;
        else if (w_last_byte)      w_p_next = P_WRITE;
      P_WRITE: begin
        w_p_next   = P_RESP;
        w_tx_start = 1'b1;
        w_tx_byte  = ACK;
      end
      P_READ:
        if (r_rd_wait) begin
          w_p_next   = P_RESP;
          w_tx_start = 1'b1;
          w_tx_byte  = rd_data_i[7:0];
        end
      P_RESP:
        if (w_tx_done) begin
          if (r_resp_left == 3'd1) w_p_next = P_IDLE;
          else begin
            w_tx_start = 1'b1;
            w_tx_byte  = r_resp[7:0];
          end
        end
      default: w_p_next = P_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_p_state   <= P_IDLE;
      r_is_wr     <= 1'b0;
      r_rd_wait   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_halt      <= 1'b0;
      r_bcnt      <= '0;
      r_resp_left <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_resp      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_addr   <= '0;
    end else begin
      r_p_state <= w_p_next;
      r_wr_en   <= (r_p_state == P_DATA) && (w_p_next == P_WRITE);
      if (r_p_state == P_IDLE)         r_bcnt <= '0;
      else if (w_collect && r_rx_valid) r_bcnt <= r_bcnt + 2'd1;
      case (r_p_state)
        P_IDLE:
          if (r_rx_valid) begin
            if (w_cmd_ok) begin
              r_is_wr <= (r_rx_byte == CMD_W);
              r_halt  <= 1'b1;
            end else begin
              r_resp_left <= 3'd1;
            end
          end
        P_ADDR:
          if (r_rx_valid) begin
            r_addr <= {r_rx_byte, r_addr[31:8]};
            if (r_bcnt == 2'd3 && !r_is_wr) r_rd_addr <= {r_rx_byte, r_addr[31:8]};
          end
        P_DATA:
          if (r_rx_valid) begin
            r_data <= {r_rx_byte, r_data[31:8]};
            if (r_bcnt == 2'd3) begin
              r_wr_addr <= r_addr;
              r_wr_data <= {r_rx_byte, r_data[31:8]};
            end
          end
        P_WRITE: r_resp_left <= 3'd1;
        P_READ: begin
          // Two-cycle wait for the target's registered read path.
          r_rd_wait <= ~r_rd_wait;
          if (r_rd_wait) begin
            r_resp      <= {8'h00, rd_data_i[31:8]};
            r_resp_left <= 3'd4;
          end
        end
        P_RESP:
          if (w_tx_done) begin
            r_resp_left <= r_resp_left - 3'd1;
            r_resp      <= r_resp >> 8;
          end
        default: ;
      endcase
      // Every path back to idle (done, framing error, timeout) releases the bus.
      if (w_p_next == P_IDLE) r_halt <= 1'b0;
    end
  end

  assign uart_tx   = r_tx;
  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign rd_addr_o = r_rd_addr;
  assign halt_o    = r_halt;
endmodule

// File: tb/tb_uart_debug_master.sv
`timescale 1ns/1ps
module tb_uart_debug_master;
  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BIT_CLKS = CLK_FREQ / UART_BPS;
  localparam int TO_CYC   = 3000;

  logic        clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx, wr_en_o, halt_o;
  logic [31:0] wr_addr_o, wr_data_o, rd_addr_o, rd_data_i;

  uart_debug_master #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .sys_clk(clk), .sys_reset(sys_reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .halt_o(halt_o));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Bus read model: target registers the address, data valid the next cycle.
  logic [31:0] rd_q = 32'h0;
  always @(posedge clk) rd_q <= rd_addr_o;
  assign rd_data_i = (rd_q == 32'h2000_0008) ? 32'h1234_5678 : (rd_q ^ 32'hA5A5_5A5A);

  // Scoreboard queues
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_wa[$], exp_wd[$];
  int          tx_starts[$];
  int          wr_count = 0;
  logic        tx_abort = 1'b0;

  // Write monitor
  logic [31:0] m_ea, m_ed;
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_wa.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr_o, wr_data_o);
      end else begin
        m_ea = exp_wa.pop_front();
        m_ed = exp_wd.pop_front();
        if (wr_addr_o !== m_ea || wr_data_o !== m_ed) begin
          errors++;
          $display("FAIL wr_bus: got addr=%h data=%h, required addr=%h data=%h", wr_addr_o, wr_data_o, m_ea, m_ed);
        end
      end
    end
  end

  // Serial TX monitor: decodes bytes at mid-bit and pops the expected queue.
  initial begin : tx_mon
    logic [7:0] b;
    logic       sb;
    logic [7:0] e;
    int         t0;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && sys_reset === 1'b0) begin
        t0 = cyc;
        tx_abort = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BIT_CLKS) @(negedge clk);
        sb = uart_tx;
        if (!tx_abort) begin
          tx_starts.push_back(t0);
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got byte %h, required no serial output", b);
          end else begin
            e = exp_tx.pop_front();
            if (b !== e || sb !== 1'b1) begin
              errors++;
              $display("FAIL tx_byte: got %h stop=%b, required %h stop=1", b, sb, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic uart_send(input logic [7:0] b, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) uart_send(bytes[8*i +: 8], 1'b1);
  endtask

  // Bounded wait until scoreboard empty and bus released.
  task automatic wait_drain(input int budget, output logic ok);
    int k;
    k = 0;
    while ((exp_tx.size() != 0 || exp_wa.size() != 0 || halt_o !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (k < budget);
    if (!ok) begin
      exp_tx.delete(); exp_wa.delete(); exp_wd.delete();
    end
  endtask

  task automatic test_reset;
    int bad;
    sys_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({uart_tx, wr_en_o, halt_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: got tx/wr/halt=%b, required 100", {uart_tx, wr_en_o, halt_o});
    end
    checks++;
    if ({wr_addr_o, wr_data_o, rd_addr_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h %h %h, required all zero", wr_addr_o, wr_data_o, rd_addr_o);
    end
    sys_reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || halt_o !== 1'b0 || wr_en_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_write;
    logic ok;
    int   w0;
    w0 = wr_count;
    exp_wa.push_back(32'h2000_0010); exp_wd.push_back(32'hDEAD_BEEF); exp_tx.push_back(8'h06);
    uart_send(8'h57, 1'b1);
    checks++;
    if (halt_o !== 1'b1) begin
      errors++;
      $display("FAIL halt_rise: got %b, required 1", halt_o);
    end
    send_frame(72'hDEADBEEF_2000_0010_00 >> 8, 8);
    wait_drain(2000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL write_drain: got timeout, required ACK and halt=0"); end
    checks++;
    if (wr_count - w0 != 1) begin errors++; $display("FAIL write_count: got %0d, required 1", wr_count - w0); end
    checks++;
    if (wr_addr_o !== 32'h2000_0010 || wr_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_hold: got %h/%h, required 20000010/deadbeef", wr_addr_o, wr_data_o);
    end
  endtask

  task automatic test_read;
    logic ok;
    int   bad;
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56); exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    tx_starts.delete();
    send_frame(72'h20_0000_0852, 5);
    wait_drain(2000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL read_drain: got timeout, required 4 bytes and halt=0"); end
    checks++;
    if (rd_addr_o !== 32'h2000_0008) begin errors++; $display("FAIL read_addr: got %h, required 20000008", rd_addr_o); end
    bad = 0;
    for (int i = 1; i < tx_starts.size(); i++)
      if (tx_starts[i] - tx_starts[i-1] != 10 * BIT_CLKS) bad++;
    checks++;
    if (tx_starts.size() != 4 || bad != 0) begin
      errors++;
      $display("FAIL read_b2b: got %0d bytes, %0d bad gaps, required 4 bytes, 0 bad gaps", tx_starts.size(), bad);
    end
  endtask

  task automatic test_nak;
    logic        ok;
    int          w0;
    logic [31:0] ra;
    w0 = wr_count;
    ra = rd_addr_o;
    exp_tx.push_back(8'h15);
    uart_send(8'hA5, 1'b1);
    checks++;
    if (halt_o !== 1'b0) begin errors++; $display("FAIL nak_halt: got %b, required 0", halt_o); end
    wait_drain(1000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL nak_drain: got timeout, required NAK"); end
    checks++;
    if (wr_count != w0 || rd_addr_o !== ra) begin
      errors++;
      $display("FAIL nak_bus: got writes=%0d rd_addr=%h, required writes=%0d rd_addr=%h", wr_count - w0, rd_addr_o, 0, ra);
    end
  endtask

  task automatic test_framing;
    int bad;
    bad = 0;
    uart_send(8'h57, 1'b0);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (halt_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL framing_halt: got %0d cycles high, required 0", bad); end
  endtask

  task automatic test_timeout;
    int   w0;
    logic ok;
    w0 = wr_count;
    send_frame(72'h00_1057, 3);
    checks++;
    if (halt_o !== 1'b1) begin errors++; $display("FAIL to_halt_rise: got %b, required 1", halt_o); end
    repeat (TO_CYC + 200) @(negedge clk);
`ifdef UART_DBG_TIMEOUT_EN
    checks++;
    if (halt_o !== 1'b0 || wr_count != w0) begin
      errors++;
      $display("FAIL timeout_drop: got halt=%b writes=%0d, required halt=0 writes=0", halt_o, wr_count - w0);
    end
    exp_wa.push_back(32'h2000_0020); exp_wd.push_back(32'h0BAD_F00D); exp_tx.push_back(8'h06);
    send_frame(72'h0BADF00D_2000_0020_57, 9);
    wait_drain(2000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL timeout_recover: got timeout, required ACK"); end
`else
    checks++;
    if (halt_o !== 1'b1 || wr_count != w0) begin
      errors++;
      $display("FAIL no_timeout: got halt=%b writes=%0d, required halt=1 writes=0", halt_o, wr_count - w0);
    end
    @(posedge clk); #1 sys_reset = 1'b1;
    @(posedge clk); #1 sys_reset = 1'b0;
    ok = (halt_o === 1'b0);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL to_reset_halt: got %b, required 0", halt_o); end
`endif
  endtask

  task automatic test_reset_mid_ack;
    logic ok;
    exp_wa.push_back(32'h0000_0040); exp_wd.push_back(32'h1357_9BDF); exp_tx.push_back(8'h06);
    send_frame(72'h13579BDF_0000_0040_57, 9);
    repeat (40) @(posedge clk);
    #1;
    tx_abort  = 1'b1;
    sys_reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (uart_tx !== 1'b1 || halt_o !== 1'b0 || wr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_ack: got tx=%b halt=%b wr_addr=%h, required 1 0 0", uart_tx, halt_o, wr_addr_o);
    end
    sys_reset = 1'b0;
    exp_tx.delete();
    checks++;
    if (exp_wa.size() != 0) begin errors++; $display("FAIL reset_mid_ack_wr: got %0d pending writes, required 0", exp_wa.size()); end
    exp_wa.delete(); exp_wd.delete();
    repeat (100) @(posedge clk);
    #1;
    // 0x100 ^ A5A55A5A = A5A55B5A
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5B); exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
    send_frame(72'h00_0001_0052, 5);
    wait_drain(2000, ok);
    checks++;
    if (ok !== 1'b1 || rd_addr_o !== 32'h0000_0100) begin
      errors++;
      $display("FAIL read_after_reset: got ok=%b rd_addr=%h, required ok=1 rd_addr=00000100", ok, rd_addr_o);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_nak;
    test_framing;
    test_timeout;
    test_reset_mid_ack;
    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
